// File: rtl/onehot_scan_decoder_pkg.sv
// rtl/onehot_scan_decoder_pkg.sv - shared state and mode codes for the one-hot scan decoder
package onehot_scan_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_scan_decoder_decode.sv
// rtl/onehot_scan_decoder_decode.sv - combinational binary to one-hot decoder
module onehot_decode #(
   parameter int SEL_W = 3,
   parameter int N_OUT = 8
) (
   input  logic [SEL_W-1:0] i_in,
   output logic [N_OUT-1:0] o_out
);

   // Bit i is set only when the index equals i; out-of-range indices give all-zero
   always_comb begin
      o_out = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (i_in == SEL_W'(i)) begin
            o_out[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot select with direct hold and dwell-timed scan
module onehot_scan_decoder
   import onehot_scan_decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int N_OUT   = 8,
   parameter int DWELL_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_mode,
   input  logic [SEL_W-1:0]   cmd_index,
   input  logic [SEL_W-1:0]   cmd_last,
   input  logic [DWELL_W-1:0] cmd_dwell,
   input  logic               abort,
   input  logic               out_en,
   output logic [N_OUT-1:0]   out,
   output logic [SEL_W-1:0]   cur_index,
   output logic               busy,
   output logic               scan_done,
   output logic               cmd_err
);

   // One extra bit so N_OUT == 2**SEL_W is representable in the range compare
   localparam logic [SEL_W:0]   LP_N_OUT = (SEL_W + 1)'(N_OUT);
   localparam logic [SEL_W-1:0] LP_MAX   = SEL_W'(N_OUT - 1);

   state_t             r_state;
   logic [SEL_W-1:0]   r_cur;
   logic [SEL_W-1:0]   r_last;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_done;
   logic               r_err;

   state_t             w_state_nxt;
   logic [SEL_W-1:0]   w_cur_nxt;
   logic [SEL_W-1:0]   w_last_nxt;
   logic [DWELL_W-1:0] w_dwell_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               w_done_nxt;
   logic               w_err_nxt;
   logic               w_bad_cmd;
   logic [SEL_W-1:0]   w_cur_inc;
   logic [N_OUT-1:0]   w_dec;
   logic [N_OUT-1:0]   w_out_q;

   assign w_bad_cmd = ({1'b0, cmd_index} >= LP_N_OUT) ||
                      ((cmd_mode == MODE_SCAN) && ({1'b0, cmd_last} >= LP_N_OUT));

   // Scan position wraps at N_OUT-1, not at the natural 2**SEL_W boundary
   assign w_cur_inc = (r_cur == LP_MAX) ? '0 : r_cur + SEL_W'(1);

   assign cmd_ready = (r_state != ST_SCAN) && !abort;

   // State register plus scan bookkeeping and the one-cycle status pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_last  <= '0;
         r_dwell <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_last  <= w_last_nxt;
         r_dwell <= w_dwell_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state: abort wins, SCAN runs the dwell timer, IDLE/HOLD take commands
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_last_nxt  = r_last;
      w_dwell_nxt = r_dwell;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_SCAN: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - DWELL_W'(1);
               end else if (r_cur != r_last) begin
                  w_cur_nxt = w_cur_inc;
                  w_cnt_nxt = r_dwell;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               if (cmd_valid) begin
                  if (w_bad_cmd) begin
                     w_err_nxt = 1'b1;
                  end else if (cmd_mode == MODE_DIRECT) begin
                     w_state_nxt = ST_HOLD;
                     w_cur_nxt   = cmd_index;
                  end else begin
                     w_state_nxt = ST_SCAN;
                     w_cur_nxt   = cmd_index;
                     w_last_nxt  = cmd_last;
                     w_dwell_nxt = cmd_dwell;
                     w_cnt_nxt   = cmd_dwell;
                  end
               end
            end
         endcase
      end
   end

   onehot_decode #(
      .SEL_W (SEL_W),
      .N_OUT (N_OUT)
   ) u_decode (
      .i_in  (r_cur),
      .o_out (w_dec)
   );

   assign w_out_q   = w_dec & {N_OUT{r_state != ST_IDLE}};
   assign out       = w_out_q & {N_OUT{out_en}};
   assign cur_index = r_cur;
   assign busy      = (r_state == ST_SCAN);
   assign scan_done = r_done;
   assign cmd_err   = r_err;

endmodule
